amo_rmw_unit: RTL and testbench

Cache-subsystem-side executor for atomic memory operations; sits directly downstream of the AMO request buffer and consumes its amo_req_t / produces amo_resp_t.
Performs LR/SC with a single reservation register and read-modify-write for AMOSWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU on a simple req/gnt/rvalid memory port.
One AMO in flight at a time, strictly in order.

---
 rtl/ariane_pkg.sv | 50 +++++
 rtl/riscv.sv | 4 +
 rtl/amo_alu.sv | 48 ++++
 rtl/amo_rmw_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_amo_rmw_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// AMO request/response types shared between the AMO request buffer and the
// AMO read-modify-write executor, plus the executor's FSM state encoding.
package ariane_pkg;

    typedef enum logic [3:0] {
        AMO_NONE = 4'b0000,
        AMO_LR   = 4'b0001,
        AMO_SC   = 4'b0010,
        AMO_SWAP = 4'b0011,
        AMO_ADD  = 4'b0100,
        AMO_AND  = 4'b0101,
        AMO_OR   = 4'b0110,
        AMO_XOR  = 4'b0111,
        AMO_MAX  = 4'b1000,
        AMO_MAXU = 4'b1001,
        AMO_MIN  = 4'b1010,
        AMO_MINU = 4'b1011,
        AMO_CAS1 = 4'b1100,
        AMO_CAS2 = 4'b1101
    } amo_t;

    typedef struct packed {
        logic        req;
        amo_t        amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } amo_rmw_state_e;

    // Operations that read memory, combine, and write back.
    function automatic logic is_rmw(amo_t op);
        return op inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
                          AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU};
    endfunction

endpackage

// File: rtl/riscv.sv
// Physical address width shared by the cache subsystem.
package riscv;
    localparam int unsigned PLEN = 56;
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational AMO combine stage.
//   op_i/size_i/lane_i : operation, access size (2'b10 = word), word lane (addr[2])
//   old_i              : 64-bit memory line value
//   operand_i          : store operand (word ops use bits [31:0])
//   wdata_o/be_o       : write data (word result replicated in both lanes) and byte enables
//   old_sext_o         : old value of the accessed lane, sign-extended to 64 bits
module amo_alu
    import ariane_pkg::*;
(
    input  amo_t        op_i,
    input  logic [1:0]  size_i,
    input  logic        lane_i,
    input  logic [63:0] old_i,
    input  logic [63:0] operand_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  be_o,
    output logic [63:0] old_sext_o
);
    logic               is_word;
    logic [31:0]        old_w;
    logic [63:0]        a_u, b_u, res;
    logic signed [63:0] a_s, b_s;

    // Word operands are widened so one 64-bit datapath serves both sizes:
    // zero-extended for unsigned compares, sign-extended for signed ones.
    always_comb begin
        is_word = (size_i == 2'b10);
        old_w   = lane_i ? old_i[63:32] : old_i[31:0];
        a_u     = is_word ? {32'b0, old_w} : old_i;
        b_u     = is_word ? {32'b0, operand_i[31:0]} : operand_i;
        a_s     = is_word ? {{32{old_w[31]}}, old_w} : old_i;
        b_s     = is_word ? {{32{operand_i[31]}}, operand_i[31:0]} : operand_i;
        case (op_i)
            AMO_ADD:  res = a_u + b_u;
            AMO_AND:  res = a_u & b_u;
            AMO_OR:   res = a_u | b_u;
            AMO_XOR:  res = a_u ^ b_u;
            AMO_MAX:  res = (a_s > b_s) ? a_u : b_u;
            AMO_MAXU: res = (a_u > b_u) ? a_u : b_u;
            AMO_MIN:  res = (a_s < b_s) ? a_u : b_u;
            AMO_MINU: res = (a_u < b_u) ? a_u : b_u;
            default:  res = b_u;
        endcase
        wdata_o    = is_word ? {res[31:0], res[31:0]} : res;
        be_o       = is_word ? (lane_i ? 8'hF0 : 8'h0F) : 8'hFF;
        old_sext_o = a_s;
    end
endmodule

// File: rtl/amo_rmw_unit.sv
// amo_rmw_unit: executes one AMO at a time (LR/SC with a single reservation,
// read-modify-write for SWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU) on a
// req/gnt/rvalid memory port.
//   amo_req_i/amo_resp_o : level request held until the 1-cycle ack pulse
//   mem_*                : memory port, request held until mem_gnt_i,
//                          completion (read data or write done) on mem_rvalid_i
//   inval_valid_i/addr_i : external store/snoop that kills a matching reservation
// Optional macro AMO_RSV_TIMEOUT_EN: reservation expires RSV_TIMEOUT cycles
// after it is set.
module amo_rmw_unit
    import ariane_pkg::*;
#(
    parameter int unsigned RSV_TIMEOUT = 128,
    parameter int unsigned RSV_GRAN    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  amo_req_t               amo_req_i,
    output amo_resp_t              amo_resp_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [riscv::PLEN-1:0] mem_addr_o,
    output logic [63:0]            mem_wdata_o,
    output logic [7:0]             mem_be_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [63:0]            mem_rdata_i,
    input  logic                   inval_valid_i,
    input  logic [riscv::PLEN-1:0] inval_addr_i
);
    localparam int unsigned PLEN = riscv::PLEN;

    amo_rmw_state_e        state_q, state_d;
    amo_t                  op_q, op_d;
    logic [1:0]            size_q, size_d;
    logic [PLEN-1:0]       addr_q, addr_d;
    logic [63:0]           opb_q, opb_d;
    logic                  ack_q, ack_d;
    logic [63:0]           result_q, result_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [PLEN-1:0]       mem_addr_q, mem_addr_d;
    logic [63:0]           mem_wdata_q, mem_wdata_d;
    logic [7:0]            mem_be_q, mem_be_d;
    logic                  rsv_valid_q, rsv_valid_d;
    logic [PLEN-1:RSV_GRAN] rsv_gran_q, rsv_gran_d;
    logic                  lr_kill_q, lr_kill_d;

    logic                  is_idle, inval_cur, inval_rsv, rsv_expired, rsv_live, rsv_match;
    amo_t                  cur_op;
    logic [1:0]            cur_size;
    logic [PLEN-1:0]       cur_addr;
    logic [63:0]           cur_opb, alu_wdata, alu_old;
    logic [7:0]            alu_be;
    logic                  unused_bits;

    // In IDLE the request is being accepted this cycle, so decode straight
    // from the input; afterwards use the latched copy.
    assign is_idle   = (state_q == IDLE);
    assign cur_op    = is_idle ? amo_req_i.amo_op : op_q;
    assign cur_size  = is_idle ? amo_req_i.size : size_q;
    assign cur_addr  = is_idle ? amo_req_i.operand_a[PLEN-1:0] : addr_q;
    assign cur_opb   = is_idle ? amo_req_i.operand_b : opb_q;
    assign inval_cur = inval_valid_i && (inval_addr_i[PLEN-1:RSV_GRAN] == cur_addr[PLEN-1:RSV_GRAN]);
    assign inval_rsv = inval_valid_i && (inval_addr_i[PLEN-1:RSV_GRAN] == rsv_gran_q);
    assign rsv_match = (rsv_gran_q == cur_addr[PLEN-1:RSV_GRAN]);
    assign rsv_live  = rsv_valid_q && !rsv_expired && !inval_rsv;

`ifdef AMO_RSV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(RSV_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign rsv_expired = rsv_valid_q && (cnt_q == '0);
`else
    assign rsv_expired = 1'b0;
`endif

    assign unused_bits = ^{amo_req_i.operand_a[63:PLEN], inval_addr_i[RSV_GRAN-1:0],
                           addr_q[1:0], RSV_TIMEOUT[0]};

    amo_alu u_alu (
        .op_i       (cur_op),
        .size_i     (cur_size),
        .lane_i     (cur_addr[2]),
        .old_i      (mem_rdata_i),
        .operand_i  (cur_opb),
        .wdata_o    (alu_wdata),
        .be_o       (alu_be),
        .old_sext_o (alu_old)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        size_d      = size_q;
        addr_d      = addr_q;
        opb_d       = opb_q;
        ack_d       = 1'b0;
        result_d    = result_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rsv_valid_d = rsv_live;
        rsv_gran_d  = rsv_gran_q;
        lr_kill_d   = lr_kill_q || inval_cur;
`ifdef AMO_RSV_TIMEOUT_EN
        cnt_d = cnt_q;
        if (rsv_valid_q && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (amo_req_i.req) begin
                    op_d      = amo_req_i.amo_op;
                    size_d    = amo_req_i.size;
                    addr_d    = cur_addr;
                    opb_d     = amo_req_i.operand_b;
                    lr_kill_d = inval_cur;
                    if (amo_req_i.amo_op == AMO_LR || is_rmw(amo_req_i.amo_op)) begin
                        if (is_rmw(amo_req_i.amo_op) && rsv_match) rsv_valid_d = 1'b0;
                        state_d    = RD_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_be_d   = 8'hFF;
                        mem_addr_d = {cur_addr[PLEN-1:3], 3'b000};
                    end else if (amo_req_i.amo_op == AMO_SC) begin
                        rsv_valid_d = 1'b0;
                        if (rsv_live && rsv_match) begin
                            state_d     = WR_REQ;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_be_d    = alu_be;
                            mem_wdata_d = alu_wdata;
                            mem_addr_d  = {cur_addr[PLEN-1:3], 3'b000};
                            result_d    = 64'd0;
                        end else begin
                            state_d  = RESP;
                            ack_d    = 1'b1;
                            result_d = 64'd1;
                        end
                    end else begin
                        state_d  = RESP;
                        ack_d    = 1'b1;
                        result_d = 64'd0;
                    end
                end
            end
            RD_REQ: if (mem_gnt_i) begin
                mem_req_d = 1'b0;
                state_d   = RD_WAIT;
            end
            RD_WAIT: if (mem_rvalid_i) begin
                result_d = alu_old;
                if (op_q == AMO_LR) begin
                    // A snoop hit at any point of the LR, including this
                    // cycle, prevents the reservation from being armed.
                    rsv_valid_d = !(lr_kill_q || inval_cur);
                    rsv_gran_d  = addr_q[PLEN-1:RSV_GRAN];
`ifdef AMO_RSV_TIMEOUT_EN
                    cnt_d = CNT_W'(RSV_TIMEOUT);
`endif
                    state_d = RESP;
                    ack_d   = 1'b1;
                end else begin
                    state_d     = WR_REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_be_d    = alu_be;
                    mem_wdata_d = alu_wdata;
                end
            end
            WR_REQ: if (mem_gnt_i) begin
                mem_req_d = 1'b0;
                state_d   = WR_WAIT;
            end
            WR_WAIT: if (mem_rvalid_i) begin
                state_d = RESP;
                ack_d   = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        op_q       <= op_d;
        size_q     <= size_d;
        addr_q     <= addr_d;
        opb_q      <= opb_d;
        rsv_gran_q <= rsv_gran_d;
        if (!rst_ni) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            result_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rsv_valid_q <= 1'b0;
            lr_kill_q   <= 1'b0;
`ifdef AMO_RSV_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            result_q    <= result_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rsv_valid_q <= rsv_valid_d;
            lr_kill_q   <= lr_kill_d;
`ifdef AMO_RSV_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign amo_resp_o  = '{ack: ack_q, result: result_q};
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
endmodule

// File: tb/tb_amo_rmw_unit.sv
// Directed bench for amo_rmw_unit with a zero-wait memory responder that can
// withhold write grants.
module tb_amo_rmw_unit;
    import ariane_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    amo_req_t    req_s;
    amo_resp_t   resp;
    logic        mem_req, mem_we, mem_gnt;
    logic [55:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        inv_v;
    logic [55:0] inv_a;

    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_be = '0;
    logic [55:0] last_waddr = '0;
    logic        wr_block = 1'b0;
    logic [63:0] wr_merge;
    logic [63:0] mem [logic [55:0]];

    always #5 clk = ~clk;

    amo_rmw_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .amo_req_i    (req_s),
        .amo_resp_o   (resp),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .inval_valid_i(inv_v),
        .inval_addr_i (inv_a)
    );

    assign mem_gnt = mem_req && !(wr_block && mem_we);

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
        end else begin
            mem_rvalid <= mem_req && mem_gnt;
            if (mem_req && mem_gnt) begin
                hs_cnt++;
                if (mem_we) begin
                    wr_merge = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
                    for (int b = 0; b < 8; b++)
                        if (mem_be[b]) wr_merge[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    mem[mem_addr] = wr_merge;
                    wr_cnt++;
                    last_wdata = mem_wdata;
                    last_be    = mem_be;
                    last_waddr = mem_addr;
                end else begin
                    mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one AMO from IDLE; latency counts clock edges from acceptance to
    // the edge after which ack is visible. inv_at selects the cycle (same
    // count) during which the snoop is asserted, -1 for none.
    task automatic do_amo(input amo_t op, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] b, input int inv_at, input logic [55:0] ia,
                          output int lat, output logic [63:0] res);
        req_s.req       = 1'b1;
        req_s.amo_op    = op;
        req_s.size      = sz;
        req_s.operand_a = a;
        req_s.operand_b = b;
        inv_a           = ia;
        lat = 0;
        do begin
            inv_v = (lat == inv_at);
            @(posedge clk); #1;
            lat++;
        end while (!resp.ack && lat < 40);
        inv_v     = 1'b0;
        res       = resp.result;
        req_s.req = 1'b0;
        @(posedge clk); #1;
        chk("ack_single_pulse", {63'b0, resp.ack}, 64'd0);
    endtask

    int          lat, hs0, wc0, n, ackc;
    logic [63:0] res;

    initial begin
        rst_n = 1'b0;
        req_s = '0;
        inv_v = 1'b0;
        inv_a = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {63'b0, resp.ack}, 64'd0);
        chk("rst_result", resp.result, 64'd0);
        chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
        chk("rst_mem_addr", {8'b0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_be", {56'b0, mem_be}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AMOADD.D: 5 + 7
        mem[56'h1000] = 64'd5;
        do_amo(AMO_ADD, 2'b11, 64'h1000, 64'd7, -1, '0, lat, res);
        chk("add_lat", lat, 64'd5);
        chk("add_res", res, 64'd5);
        chk("add_wdata", last_wdata, 64'd12);
        chk("add_be", {56'b0, last_be}, 64'hFF);
        chk("add_waddr", {8'b0, last_waddr}, 64'h1000);
        chk("add_mem", mem[56'h1000], 64'd12);

        // AMOMAX.W upper lane: signed max(-1, 1) = 1
        mem[56'h1000] = 64'hFFFFFFFF_12345678;
        do_amo(AMO_MAX, 2'b10, 64'h1004, 64'h1, -1, '0, lat, res);
        chk("maxw_lat", lat, 64'd5);
        chk("maxw_res", res, 64'hFFFFFFFF_FFFFFFFF);
        chk("maxw_wdata_hi", {32'b0, last_wdata[63:32]}, 64'h1);
        chk("maxw_be", {56'b0, last_be}, 64'hF0);
        chk("maxw_waddr", {8'b0, last_waddr}, 64'h1000);
        chk("maxw_mem", mem[56'h1000], 64'h00000001_12345678);

        // AMOSWAP.W lower lane, negative old word is sign-extended
        mem[56'h3000] = 64'h11111111_A2222222;
        do_amo(AMO_SWAP, 2'b10, 64'h3000, 64'hDEADBEEF_CAFEF00D, -1, '0, lat, res);
        chk("swapw_res", res, 64'hFFFFFFFF_A2222222);
        chk("swapw_be", {56'b0, last_be}, 64'h0F);
        chk("swapw_mem", mem[56'h3000], 64'h11111111_CAFEF00D);

        // 64-bit MINU vs MIN on a value with the top bit set
        mem[56'h3008] = 64'h80000000_00000000;
        do_amo(AMO_MINU, 2'b11, 64'h3008, 64'h1, -1, '0, lat, res);
        chk("minu_mem", mem[56'h3008], 64'h1);
        mem[56'h3008] = 64'h80000000_00000000;
        do_amo(AMO_MIN, 2'b11, 64'h3008, 64'h1, -1, '0, lat, res);
        chk("min_res", res, 64'h80000000_00000000);
        chk("min_mem", mem[56'h3008], 64'h80000000_00000000);

        // LR.D / SC.D success, then SC without reservation
        mem[56'h2000] = 64'h55;
        do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, -1, '0, lat, res);
        chk("lr_lat", lat, 64'd3);
        chk("lr_res", res, 64'h55);
        wc0 = wr_cnt;
        do_amo(AMO_SC, 2'b11, 64'h2000, 64'hAB, -1, '0, lat, res);
        chk("sc_ok_lat", lat, 64'd3);
        chk("sc_ok_res", res, 64'd0);
        chk("sc_ok_wdata", last_wdata, 64'hAB);
        chk("sc_ok_wcount", wr_cnt, wc0 + 1);
        chk("sc_ok_mem", mem[56'h2000], 64'hAB);
        hs0 = hs_cnt;
        do_amo(AMO_SC, 2'b11, 64'h2000, 64'hCD, -1, '0, lat, res);
        chk("sc_again_lat", lat, 64'd1);
        chk("sc_again_res", res, 64'd1);
        chk("sc_again_nomem", hs_cnt, hs0);

        // Snoop to the same granule during RD_WAIT kills the LR
        do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 2, 56'h2004, lat, res);
        chk("lr_inv_res", res, 64'hAB);
        hs0 = hs_cnt;
        do_amo(AMO_SC, 2'b11, 64'h2000, 64'hCD, -1, '0, lat, res);
        chk("sc_inv_res", res, 64'd1);
        chk("sc_inv_lat", lat, 64'd1);
        chk("sc_inv_nomem", hs_cnt, hs0);
        chk("sc_inv_mem", mem[56'h2000], 64'hAB);

        // Snoop to the neighbouring granule leaves the reservation intact
        mem[56'h5000] = 64'h1;
        do_amo(AMO_LR, 2'b11, 64'h5000, 64'h0, 2, 56'h5008, lat, res);
        do_amo(AMO_SC, 2'b11, 64'h5000, 64'h77, -1, '0, lat, res);
        chk("sc_other_gran_res", res, 64'd0);
        chk("sc_other_gran_mem", mem[56'h5000], 64'h77);

        // RMW to the reserved granule clears the reservation
        do_amo(AMO_LR, 2'b11, 64'h4000, 64'h0, -1, '0, lat, res);
        do_amo(AMO_ADD, 2'b11, 64'h4000, 64'h1, -1, '0, lat, res);
        do_amo(AMO_SC, 2'b11, 64'h4000, 64'h9, -1, '0, lat, res);
        chk("sc_after_rmw_res", res, 64'd1);

        // AMO_NONE / CAS: immediate response, no memory traffic
        hs0 = hs_cnt;
        do_amo(AMO_NONE, 2'b11, 64'h1000, 64'h5, -1, '0, lat, res);
        chk("none_lat", lat, 64'd1);
        chk("none_res", res, 64'd0);
        do_amo(AMO_CAS1, 2'b11, 64'h1000, 64'h5, -1, '0, lat, res);
        chk("cas_res", res, 64'd0);
        chk("none_nomem", hs_cnt, hs0);

        // Write grant withheld for 10 cycles
        mem[56'h6000] = 64'hF0;
        wr_block        = 1'b1;
        req_s.req       = 1'b1;
        req_s.amo_op    = AMO_OR;
        req_s.size      = 2'b11;
        req_s.operand_a = 64'h6000;
        req_s.operand_b = 64'h0F;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_reach_wr", {63'b0, mem_req && mem_we}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_req", {63'b0, mem_req}, 64'd1);
            chk("stall_we", {63'b0, mem_we}, 64'd1);
            chk("stall_wdata", mem_wdata, 64'hFF);
            chk("stall_no_ack", {63'b0, resp.ack}, 64'd0);
            @(posedge clk); #1;
        end
        wr_block = 1'b0;
        ackc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp.ack) begin
                ackc++;
                chk("stall_res", resp.result, 64'hF0);
                req_s.req = 1'b0;
            end
        end
        chk("stall_ack_count", ackc, 64'd1);
        chk("stall_mem", mem[56'h6000], 64'hFF);

        // Reset while in WR_WAIT; the earlier reservation is lost
        mem[56'h7000] = 64'h99;
        do_amo(AMO_LR, 2'b11, 64'h7000, 64'h0, -1, '0, lat, res);
        chk("lr2_res", res, 64'h99);
        req_s.req       = 1'b1;
        req_s.amo_op    = AMO_ADD;
        req_s.size      = 2'b11;
        req_s.operand_a = 64'h8000;
        req_s.operand_b = 64'h1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_wr_done", {63'b0, mem_rvalid}, 64'd1);
        rst_n     = 1'b0;
        req_s.req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ack", {63'b0, resp.ack}, 64'd0);
        chk("midrst_mem_req", {63'b0, mem_req}, 64'd0);
        chk("midrst_result", resp.result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ack", {63'b0, resp.ack}, 64'd0);
        do_amo(AMO_SC, 2'b11, 64'h7000, 64'h3, -1, '0, lat, res);
        chk("sc_after_rst_res", res, 64'd1);
        chk("sc_after_rst_lat", lat, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
